// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
//
// Purpose: bundles the instruction-fetch port, the data port and the single
// memory port that mem_arbiter multiplexes between them.
//
// Handshake (both client ports): the client raises *_req together with its
// address (and, for the data port, d_we/d_wdata) and holds them until the
// arbiter returns a one-cycle *_ack. *_rdata is valid in the ack cycle and
// holds until the next ack for that port. err pulses together with an ack
// whose memory access timed out. On the memory side, mem_en is a one-cycle
// start strobe. mem_we/mem_addr/mem_wdata are stable from that strobe until
// the arbiter returns to idle. The memory answers with a one-cycle mem_valid
// (with mem_rdata) at least one cycle after mem_en.
//
// Modports:
//   slave  - the arbiter's view (requests and memory responses in,
//            acks, read data and memory commands out)
//   master - the environment's view (clients plus memory model)
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
    // Control / instruction-fetch port
    logic        halt;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;

    // Data port
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;

    // Timeout indication
    logic        err;

    // Memory port
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;

    modport slave (
        input  halt,
        input  i_req,
        input  i_addr,
        output i_ack,
        output i_rdata,
        input  d_req,
        input  d_we,
        input  d_addr,
        input  d_wdata,
        output d_ack,
        output d_rdata,
        output err,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_valid
    );

    modport master (
        output halt,
        output i_req,
        output i_addr,
        input  i_ack,
        input  i_rdata,
        output d_req,
        output d_we,
        output d_addr,
        output d_wdata,
        input  d_ack,
        input  d_rdata,
        input  err,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares one memory port between the instruction-fetch (I) and the
// data (D) side of a small 16-bit CPU. One transaction is in flight at a time,
// tracked by a three-state FSM: IDLE -> BUSY -> RESP -> IDLE.
//   IDLE : pick a winner, latch owner and memory command, strobe mem_en.
//   BUSY : wait for mem_valid, or abort after TIMEOUT cycles (err=1, data 0).
//   RESP : one-cycle ack to the owner; requests are not looked at here, so a
//          request still held during its own ack is never granted twice.
// D beats I on a tie (the data access belongs to the older pipeline stage).
// While halt=1 the I side cannot win a new grant; an I access already under
// way completes normally.
//
// Parameters:
//   TIMEOUT     - maximum BUSY cycles before the access is aborted (>= 2)
//   D_BURST_MAX - consecutive contested D grants before I is forced in
//                 (only meaningful when ARB_FAIRNESS_EN is defined)
//
// Optional feature: define ARB_FAIRNESS_EN to add the D-burst limiter. Without
// it, arbitration is strict D priority and the burst counter does not exist.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst     - synchronous active-high reset
//   bus     - mem_arbiter_if.slave (client ports, err, memory port)
//   state_o - current FSM state (0=IDLE, 1=BUSY, 2=RESP) for observation
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int TIMEOUT     = 64,
    parameter int D_BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // The BUSY counter runs 0 .. TIMEOUT-1; the abort fires in the cycle the
    // counter holds TIMEOUT-1, i.e. after exactly TIMEOUT BUSY cycles.
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 2");
    end
    if (D_BURST_MAX < 1) begin : g_bad_burst
        $error("mem_arbiter: D_BURST_MAX must be at least 1");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t         state_q;
    logic           owner_d_q;      // 1: D owns the current access, 0: I
    logic           mem_en_q;
    logic           mem_we_q;
    logic [15:0]    mem_addr_q;
    logic [15:0]    mem_wdata_q;
    logic           i_ack_q;
    logic           d_ack_q;
    logic           err_q;
    logic [15:0]    i_rdata_q;
    logic [15:0]    d_rdata_q;
    logic [CW-1:0]  busy_cnt_q;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic           i_elig;
    logic           d_elig;
    logic           win_i;
    logic           win_d;
    logic [CW-1:0]  busy_cnt_d;
    logic           timed_out;

    assign i_elig     = bus.i_req && !bus.halt;
    assign d_elig     = bus.d_req;
    assign busy_cnt_d = busy_cnt_q + 1'b1;
    assign timed_out  = (busy_cnt_q == CNT_LAST);

`ifdef ARB_FAIRNESS_EN
    // burst_q counts back-to-back D grants made while I was also eligible.
    // Once it reaches D_BURST_MAX, the next contested grant goes to I.
    // An I grant, or a D grant with no I waiting, ends the run.
    localparam int BW = $clog2(D_BURST_MAX + 1);

    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_d;
    logic          force_i;

    always_comb begin
        force_i = d_elig && i_elig && (burst_q == BW'(D_BURST_MAX));
        win_i   = i_elig && (!d_elig || force_i);
        win_d   = d_elig && !win_i;
        burst_d = burst_q;
        if (win_i) begin
            burst_d = '0;
        end else if (win_d) begin
            burst_d = i_elig ? (burst_q + 1'b1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else if (state_q == IDLE) begin
            burst_q <= burst_d;
        end
    end
`else
    always_comb begin
        win_d = d_elig;
        win_i = i_elig && !d_elig;
    end
`endif

    // ------------------------------------------------------------------
    // Main FSM, all outputs registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            i_rdata_q   <= 16'h0000;
            d_rdata_q   <= 16'h0000;
            busy_cnt_q  <= '0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle below.
            mem_en_q <= 1'b0;
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (win_i || win_d) begin
                        state_q     <= BUSY;
                        owner_d_q   <= win_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= win_d && bus.d_we;
                        mem_addr_q  <= win_d ? bus.d_addr : bus.i_addr;
                        // Fetches never write; drive a clean zero for them.
                        mem_wdata_q <= win_d ? bus.d_wdata : 16'h0000;
                        busy_cnt_q  <= '0;
                    end
                end

                BUSY: begin
                    // mem_valid wins over a timeout landing in the same cycle.
                    if (bus.mem_valid || timed_out) begin
                        state_q <= RESP;
                        err_q   <= !bus.mem_valid;
                        if (owner_d_q) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= bus.mem_valid ? bus.mem_rdata : 16'h0000;
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= bus.mem_valid ? bus.mem_rdata : 16'h0000;
                        end
                    end else begin
                        busy_cnt_q <= busy_cnt_d;
                    end
                end

                RESP: begin
                    state_q    <= IDLE;
                    busy_cnt_q <= '0;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter built with TIMEOUT=8 and D_BURST_MAX=4. A per-cycle
// vector table covers the basic fetch, the D-over-I tie and stray mem_valid;
// hand-written sequences cover reset, timeout, halt, reset mid-access and the
// grant order under continuous contention (with or without ARB_FAIRNESS_EN).
// Inputs change away from the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int         NV     = 15;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_o;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT     (8),
        .D_BURST_MAX (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    // Memory responder: answers a mem_en one cycle later when resp_on=1.
    logic        resp_on = 1'b0;
    logic        mv_pend = 1'b0;

    typedef struct {
        logic        i_req;
        logic [15:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        mem_valid;
        logic [15:0] mem_rdata;
        logic [1:0]  e_state;
        logic        e_mem_en;
        logic        e_mem_we;
        logic [15:0] e_mem_addr;
        logic [15:0] e_mem_wdata;
        logic        e_i_ack;
        logic [15:0] e_i_rdata;
        logic        e_d_ack;
        logic [15:0] e_d_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mkv(
        input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
        input logic [15:0] da, input logic [15:0] dd, input logic mv, input logic [15:0] mr,
        input logic [1:0] es, input logic ee, input logic ew, input logic [15:0] ea,
        input logic [15:0] ed, input logic eia, input logic [15:0] eir,
        input logic eda, input logic [15:0] edr, input logic eer);
        vec_t v;
        v.i_req = ir;  v.i_addr = ia;  v.d_req = dr;  v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd; v.mem_valid = mv; v.mem_rdata = mr;
        v.e_state = es; v.e_mem_en = ee; v.e_mem_we = ew; v.e_mem_addr = ea;
        v.e_mem_wdata = ed; v.e_i_ack = eia; v.e_i_rdata = eir;
        v.e_d_ack = eda; v.e_d_rdata = edr; v.e_err = eer;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_state"},   16'(state_o),       16'(S_IDLE));
        check({pfx, "_mem_en"},  16'(bus.mem_en),    16'h0);
        check({pfx, "_mem_we"},  16'(bus.mem_we),    16'h0);
        check({pfx, "_addr"},    bus.mem_addr,       16'h0);
        check({pfx, "_wdata"},   bus.mem_wdata,      16'h0);
        check({pfx, "_i_ack"},   16'(bus.i_ack),     16'h0);
        check({pfx, "_i_rdata"}, bus.i_rdata,        16'h0);
        check({pfx, "_d_ack"},   16'(bus.d_ack),     16'h0);
        check({pfx, "_d_rdata"}, bus.d_rdata,        16'h0);
        check({pfx, "_err"},     16'(bus.err),       16'h0);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Advance one cycle: drive the responder's mem_valid just after the edge,
    // then stop at the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.mem_valid = resp_on & mv_pend;
        @(negedge clk);
        mv_pend = bus.mem_en;
    endtask

    // Tick until the selected ack appears; at = cycles taken, -1 if none.
    task automatic run_until_ack(input logic want_d, input int bound, output int at);
        at = -1;
        for (int c = 1; c <= bound; c++) begin
            tick();
            if ((want_d ? bus.d_ack : bus.i_ack) === 1'b1) begin
                at = c;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Test
    // ------------------------------------------------------------------
    initial begin
        int          at;
        int          cnt;
        int          grants;
        logic        err_at;
        logic [15:0] rd_at;

        rst = 1'b1;
        bus.halt = 1'b0;   bus.i_req = 1'b0;  bus.i_addr = 16'h0;
        bus.d_req = 1'b0;  bus.d_we = 1'b0;   bus.d_addr = 16'h0;
        bus.d_wdata = 16'h0; bus.mem_valid = 1'b0; bus.mem_rdata = 16'h0;

        // Vector table: one row per cycle after reset.
        //              ireq  iaddr     dreq  dwe   daddr     dwdata    mv    mrdata
        //              state   en    we    maddr     mwdata    iack  irdata    dack  drdata    err
        vecs[0]  = mkv(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                       S_IDLE, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vecs[1]  = mkv(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                       S_BUSY, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vecs[2]  = mkv(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hB123,
                       S_BUSY, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vecs[3]  = mkv(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                       S_RESP, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hB123, 1'b0, 16'h0000, 1'b0);
        vecs[4]  = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                       S_IDLE, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hB123, 1'b0, 16'h0000, 1'b0);
        vecs[5]  = mkv(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0200, 16'h00FF, 1'b0, 16'h0000,
                       S_IDLE, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hB123, 1'b0, 16'h0000, 1'b0);
        vecs[6]  = mkv(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0200, 16'h00FF, 1'b0, 16'h0000,
                       S_BUSY, 1'b1, 1'b1, 16'h0200, 16'h00FF, 1'b0, 16'hB123, 1'b0, 16'h0000, 1'b0);
        vecs[7]  = mkv(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0200, 16'h00FF, 1'b1, 16'h5555,
                       S_BUSY, 1'b0, 1'b1, 16'h0200, 16'h00FF, 1'b0, 16'hB123, 1'b0, 16'h0000, 1'b0);
        vecs[8]  = mkv(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0200, 16'h00FF, 1'b0, 16'h0000,
                       S_RESP, 1'b0, 1'b1, 16'h0200, 16'h00FF, 1'b0, 16'hB123, 1'b1, 16'h5555, 1'b0);
        vecs[9]  = mkv(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                       S_IDLE, 1'b0, 1'b1, 16'h0200, 16'h00FF, 1'b0, 16'hB123, 1'b0, 16'h5555, 1'b0);
        vecs[10] = mkv(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                       S_BUSY, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hB123, 1'b0, 16'h5555, 1'b0);
        vecs[11] = mkv(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234,
                       S_BUSY, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hB123, 1'b0, 16'h5555, 1'b0);
        vecs[12] = mkv(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hDEAD,
                       S_RESP, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h5555, 1'b0);
        vecs[13] = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hDEAD,
                       S_IDLE, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h5555, 1'b0);
        vecs[14] = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                       S_IDLE, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h5555, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Vector table
        for (int t = 0; t < NV; t++) begin
            @(posedge clk);
            #1;
            bus.i_req     = vecs[t].i_req;
            bus.i_addr    = vecs[t].i_addr;
            bus.d_req     = vecs[t].d_req;
            bus.d_we      = vecs[t].d_we;
            bus.d_addr    = vecs[t].d_addr;
            bus.d_wdata   = vecs[t].d_wdata;
            bus.mem_valid = vecs[t].mem_valid;
            bus.mem_rdata = vecs[t].mem_rdata;
            @(negedge clk);
            check($sformatf("v%0d_state", t),   16'(state_o),    16'(vecs[t].e_state));
            check($sformatf("v%0d_mem_en", t),  16'(bus.mem_en), 16'(vecs[t].e_mem_en));
            check($sformatf("v%0d_mem_we", t),  16'(bus.mem_we), 16'(vecs[t].e_mem_we));
            check($sformatf("v%0d_addr", t),    bus.mem_addr,    vecs[t].e_mem_addr);
            check($sformatf("v%0d_wdata", t),   bus.mem_wdata,   vecs[t].e_mem_wdata);
            check($sformatf("v%0d_i_ack", t),   16'(bus.i_ack),  16'(vecs[t].e_i_ack));
            check($sformatf("v%0d_i_rdata", t), bus.i_rdata,     vecs[t].e_i_rdata);
            check($sformatf("v%0d_d_ack", t),   16'(bus.d_ack),  16'(vecs[t].e_d_ack));
            check($sformatf("v%0d_d_rdata", t), bus.d_rdata,     vecs[t].e_d_rdata);
            check($sformatf("v%0d_err", t),     16'(bus.err),    16'(vecs[t].e_err));
        end

        // Reset clears data registers that now hold non-zero values
        rst = 1'b1;
        tick();
        check_all_zero("rst_data");
        rst = 1'b0;

        // Normal load so d_rdata is non-zero before the timeout case
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0300;
        bus.mem_rdata = 16'hCAFE; resp_on = 1'b1;
        run_until_ack(1'b1, 12, at);
        check("ld_latency", 16'(at), 16'd3);
        check("ld_rdata", bus.d_rdata, 16'hCAFE);
        check("ld_err", 16'(bus.err), 16'h0);
        bus.d_req = 1'b0;
        tick();
        check("ld_idle", 16'(state_o), 16'(S_IDLE));

        // Timeout: no mem_valid; request dropped mid-access must still be acked
        bus.d_req = 1'b1; bus.d_addr = 16'h0310; resp_on = 1'b0;
        at = -1; err_at = 1'b0; rd_at = 16'hFFFF;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) check("to_mem_en", 16'(bus.mem_en), 16'h1);
            if (c == 2) bus.d_req = 1'b0;
            if (bus.d_ack === 1'b1) begin
                at = c; err_at = bus.err; rd_at = bus.d_rdata;
                break;
            end
        end
        check("to_ack_cycle", 16'(at), 16'd9);
        check("to_err", 16'(err_at), 16'h1);
        check("to_rdata", rd_at, 16'h0000);
        tick();
        check("to_err_clear", 16'(bus.err), 16'h0);
        check("to_idle", 16'(state_o), 16'(S_IDLE));

        // Halt blocks I grants; release grants next cycle; in-flight I completes
        bus.halt = 1'b1; bus.i_req = 1'b1; bus.i_addr = 16'h0040;
        bus.mem_rdata = 16'h7E57; resp_on = 1'b1; cnt = 0;
        repeat (20) begin
            tick();
            if (bus.mem_en !== 1'b0 || state_o !== S_IDLE) cnt++;
        end
        check("halt_no_grant", 16'(cnt), 16'd0);
        bus.halt = 1'b0;
        tick();
        check("halt_release_en", 16'(bus.mem_en), 16'h1);
        check("halt_release_addr", bus.mem_addr, 16'h0040);
        bus.halt = 1'b1;
        run_until_ack(1'b0, 6, at);
        check("halt_inflight_ack", 16'(at), 16'd2);
        check("halt_inflight_rdata", bus.i_rdata, 16'h7E57);
        bus.i_req = 1'b0; bus.halt = 1'b0;
        tick();
        check("halt_idle", 16'(state_o), 16'(S_IDLE));

        // Reset in the second BUSY cycle, then a late mem_valid
        bus.i_req = 1'b1; bus.i_addr = 16'h0050; resp_on = 1'b0;
        tick();
        check("rm_mem_en", 16'(bus.mem_en), 16'h1);
        tick();
        check("rm_busy2", 16'(state_o), 16'(S_BUSY));
        rst = 1'b1; bus.i_req = 1'b0;
        tick();
        check_all_zero("rm_after_rst");
        rst = 1'b0; cnt = 0;
        repeat (5) begin
            bus.mem_valid = 1'b1; bus.mem_rdata = 16'hBAD0;
            tick();
            if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0 || state_o !== S_IDLE ||
                bus.i_rdata !== 16'h0) cnt++;
        end
        check("rm_stray_valid", 16'(cnt), 16'd0);
        bus.i_req = 1'b1; bus.i_addr = 16'h0060; bus.mem_rdata = 16'h0A0A; resp_on = 1'b1;
        run_until_ack(1'b0, 12, at);
        check("rm_next_latency", 16'(at), 16'd3);
        check("rm_next_rdata", bus.i_rdata, 16'h0A0A);
        bus.i_req = 1'b0;
        tick();

        // Continuous contention: grant order observed on mem_addr
`ifdef ARB_FAIRNESS_EN
        exp_q = '{16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0010, 16'h0200};
`else
        exp_q = '{16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200};
`endif
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
        bus.mem_rdata = 16'h1111; resp_on = 1'b1; grants = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (bus.mem_en === 1'b1) begin
                check($sformatf("grant%0d", grants), bus.mem_addr, exp_q.pop_front());
                grants++;
                if (grants == 6) break;
            end
        end
        check("grant_count", 16'(grants), 16'd6);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (6) tick();
        check("final_idle", 16'(state_o), 16'(S_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of cycles in BUSY before the transaction aborts.
REQ-002 Parameter D_BURST_MAX, default 4, is the number of consecutive D grants allowed while I is pending (used only with ARB_FAIRNESS_EN).
REQ-003 clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 halt  in  1  high blocks new I grants (from the decoded HLT opcode 4'b1111).
REQ-006 i_req  in  1  instruction-fetch request, held until i_ack.
REQ-007 i_addr  in  16  fetch address.
REQ-008 i_ack  out  1  one-cycle fetch completion.
REQ-009 i_rdata  out  16  fetch data, valid while i_ack=1.
REQ-010 d_req  in  1  data request from the MemRead/MemWrite control bits, held until d_ack.
REQ-011 d_we  in  1  1=store (SW), 0=load (LW/LHB/LLB).
REQ-012 d_addr  in  16  data address.
REQ-013 d_wdata  in  16  store data.
REQ-014 d_ack  out  1  one-cycle data completion.
REQ-015 d_rdata  out  16  load data, valid while d_ack=1.
REQ-016 err  out  1  one-cycle pulse alongside the ack of a timed-out transaction.
REQ-017 mem_en  out  1  one-cycle memory start strobe.
REQ-018 mem_we  out  1  write enable, valid with mem_en.
REQ-019 mem_addr  out  16  address, registered and stable from grant until return to IDLE.
REQ-020 mem_wdata  out  16  write data, registered at grant.
REQ-021 mem_rdata  in  16  memory read data, valid with mem_valid.
REQ-022 mem_valid  in  1  memory completion, at least 1 cycle after mem_en.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-024 In IDLE with any eligible request, the next state SHALL be BUSY, and the owner, mem_we, mem_addr and mem_wdata SHALL be latched from the winner.
REQ-025 mem_en SHALL be 1 only in the first BUSY cycle.
REQ-026 In BUSY, mem_valid=1 SHALL cause a move to RESP with mem_rdata captured into the owner's rdata register.
REQ-027 In RESP, the owner's ack SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-028 IDLE SHALL ignore requests during the RESP cycle, so a held request is never re-granted.
REQ-029 If i_req is first high in cycle 0 and mem_valid arrives in cycle k≥2, i_ack SHALL be 1 in cycle k+1 and the FSM SHALL be back in IDLE in cycle k+2.
REQ-030 A BUSY counter SHALL run; on reaching TIMEOUT without mem_valid the FSM SHALL go to RESP with owner ack=1, err=1 and rdata=16'h0000.
REQ-031 mem_valid outside BUSY SHALL be ignored.
REQ-032 On simultaneous i_req and d_req in IDLE, D SHALL win (older pipeline stage).
REQ-033 While halt=1, i_req SHALL be ineligible; an I transaction already in BUSY or RESP SHALL complete normally.
REQ-034 A request deasserted mid-transaction SHALL NOT abort it, and its ack SHALL still pulse.
REQ-035 rdata registers SHALL hold their value between acks.

Reset
REQ-036 rst=1 SHALL force IDLE, and all outputs, counters and data registers SHALL be 0 on the following cycle.
REQ-037 Reset mid-transaction SHALL drop the transaction without any ack, and a later mem_valid SHALL be ignored.

Configuration
REQ-038 With ARB_FAIRNESS_EN defined, a counter SHALL count consecutive D grants made while i_req is eligible.
REQ-039 With ARB_FAIRNESS_EN defined, when that counter equals D_BURST_MAX the next contested grant SHALL go to I and the counter SHALL clear.
REQ-040 With ARB_FAIRNESS_EN defined, the counter SHALL also clear on any I grant.
REQ-041 Without ARB_FAIRNESS_EN, strict D priority SHALL apply and the counter logic SHALL be absent.

Verification
REQ-042 i_req=1, i_addr=16'h0010, mem_valid 1 cycle after mem_en, mem_rdata=16'hB123 -> mem_en in cycle 1, i_ack and i_rdata=16'hB123 in cycle 3.
REQ-043 i_req and d_req high together in cycle 0, d_we=1, d_addr=16'h0200, d_wdata=16'h00FF -> mem_we=1, mem_addr=16'h0200 first; i_ack only after d_ack.
REQ-044 halt=1 with i_req=1 for 20 cycles -> no mem_en; deassert halt -> grant on the next cycle.
REQ-045 TIMEOUT=8, mem_valid never asserted -> d_ack=1, err=1, d_rdata=16'h0000 in the cycle after 8 BUSY cycles.
REQ-046 ARB_FAIRNESS_EN, D_BURST_MAX=4, both requests held continuously -> grant order D,D,D,D,I,D; without the macro, all D grants.
REQ-047 rst pulsed in the second BUSY cycle, then mem_valid -> no ack and IDLE; the next request completes normally.
